// File: rtl/llc_pkg.sv
// Shared definitions for the LLC arbiter: FSM state encoding, requester
// index constants and default interface widths.
package llc_pkg;

    localparam int unsigned LLC_ADDR_WIDTH = 64;
    localparam int unsigned LLC_LINE_WIDTH = 512;
    localparam int unsigned LLC_N_REQ      = 2;

    // Requester indices; the index also sets fixed-priority rank (higher wins).
    localparam int unsigned REQ_L1I = 0;
    localparam int unsigned REQ_L1D = 1;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StLcReq  = 2'd1,
        StLcWait = 2'd2,
        StRsp    = 2'd3
    } llc_state_e;

endpackage

// File: rtl/llc_arb_pick.sv
// Combinational winner selection for the LLC arbiter.
//
// Ports:
//   req_i          per-requester request vector
//   last_served_i  index of the requester served most recently
//   grant_o        one-hot grant (all zero when no request)
//
// Macro LLC_ARB_ROUND_ROBIN_EN: when defined, the requester following
// last_served_i in rotating order wins; otherwise the highest requesting
// index wins and last_served_i is ignored.
module llc_arb_pick import llc_pkg::*; #(
    parameter int unsigned N_REQ = LLC_N_REQ
) (
    input  logic [N_REQ-1:0]         req_i,
    input  logic [$clog2(N_REQ)-1:0] last_served_i,
    output logic [N_REQ-1:0]         grant_o
);

`ifdef LLC_ARB_ROUND_ROBIN_EN
    int best_dist;
    int dist;
`else
    logic unused_last_served;
    assign unused_last_served = ^last_served_i;
`endif

    int   win;
    logic any;

    always_comb begin
        win = 0;
        any = 1'b0;
`ifdef LLC_ARB_ROUND_ROBIN_EN
        // Distance 0 is the requester right after the last one served.
        best_dist = int'(N_REQ);
        dist      = 0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            dist = (i + int'(N_REQ) - 1 - int'(last_served_i)) % int'(N_REQ);
            if (req_i[i] && (dist < best_dist)) begin
                best_dist = dist;
                win       = i;
                any       = 1'b1;
            end
        end
`else
        // Ascending scan: the last hit is the highest index.
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (req_i[i]) begin
                win = i;
                any = 1'b1;
            end
        end
`endif
        grant_o = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            grant_o[i] = any && (win == i);
        end
    end

endmodule

// File: rtl/llc_arbiter.sv
// Arbitrates N_REQ cache requesters (0 = L1I, 1 = L1D) onto a single LLC
// port with exactly one outstanding transaction:
// IDLE -> LC_REQ -> LC_WAIT -> RSP -> IDLE.
//
// Ports:
//   clk_in, rst_in                 clock, synchronous active-high reset
//   req_*_in / req_ready_out       requester side, ready is the grant
//   rsp_valid_out / rsp_ready_in   one-hot response to the owner
//   rsp_addr_out, rsp_value_out    shared response payload
//   lc_*_out / lc_ready_in         request towards the LLC
//   lc_*_in / lc_ready_out         response from the LLC
//   owner_out, busy_out            current owner, high outside IDLE
//
// Macro LLC_ARB_ROUND_ROBIN_EN enables round-robin tie breaking with a
// last-served pointer; without it the highest index always wins.
module llc_arbiter import llc_pkg::*; #(
    parameter int unsigned ADDR_WIDTH = LLC_ADDR_WIDTH,
    parameter int unsigned LINE_WIDTH = LLC_LINE_WIDTH,
    parameter int unsigned N_REQ      = LLC_N_REQ
) (
    input  logic                                clk_in,
    input  logic                                rst_in,
    input  logic [N_REQ-1:0]                    req_valid_in,
    output logic [N_REQ-1:0]                    req_ready_out,
    input  logic [N_REQ-1:0][ADDR_WIDTH-1:0]    req_addr_in,
    input  logic [N_REQ-1:0][LINE_WIDTH-1:0]    req_value_in,
    input  logic [N_REQ-1:0]                    req_we_in,
    output logic [N_REQ-1:0]                    rsp_valid_out,
    input  logic [N_REQ-1:0]                    rsp_ready_in,
    output logic [ADDR_WIDTH-1:0]               rsp_addr_out,
    output logic [LINE_WIDTH-1:0]               rsp_value_out,
    output logic                                lc_valid_out,
    output logic [ADDR_WIDTH-1:0]               lc_addr_out,
    output logic [LINE_WIDTH-1:0]               lc_value_out,
    output logic                                lc_we_out,
    input  logic                                lc_ready_in,
    input  logic                                lc_valid_in,
    input  logic [ADDR_WIDTH-1:0]               lc_addr_in,
    input  logic [LINE_WIDTH-1:0]               lc_value_in,
    output logic                                lc_ready_out,
    output logic [$clog2(N_REQ)-1:0]            owner_out,
    output logic                                busy_out
);

    localparam int unsigned IdxW = $clog2(N_REQ);

    llc_state_e            state_q, state_d;
    logic [N_REQ-1:0]      grant;
    logic [IdxW-1:0]       win_idx;
    logic [IdxW-1:0]       last_served;
    logic [IdxW-1:0]       owner_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LINE_WIDTH-1:0] value_q;
    logic                  we_q;
    logic                  grant_fire;
    logic                  lc_rsp_fire;

    assign grant_fire  = (state_q == StIdle) && (|req_valid_in);
    assign lc_rsp_fire = (state_q == StLcWait) && lc_valid_in;

    llc_arb_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req_i         (req_valid_in),
        .last_served_i (last_served),
        .grant_o       (grant)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (grant[i]) begin
                win_idx = IdxW'(i);
            end
        end
    end

`ifdef LLC_ARB_ROUND_ROBIN_EN
    logic [IdxW-1:0] last_served_q;
    logic            rsp_fire;

    assign rsp_fire = (state_q == StRsp) && rsp_ready_in[owner_q];

    // Reset value L1I makes L1D win the first tie.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            last_served_q <= IdxW'(REQ_L1I);
        end else if (rsp_fire) begin
            last_served_q <= owner_q;
        end
    end

    assign last_served = last_served_q;
`else
    assign last_served = IdxW'(REQ_L1I);
`endif

    // State register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (|req_valid_in)         state_d = StLcReq;
            StLcReq:  if (lc_ready_in)           state_d = StLcWait;
            StLcWait: if (lc_valid_in)           state_d = StRsp;
            StRsp:    if (rsp_ready_in[owner_q]) state_d = StIdle;
            default:                             state_d = StIdle;
        endcase
    end

    // Outputs decoded from the current state.
    always_comb begin
        req_ready_out = '0;
        rsp_valid_out = '0;
        lc_valid_out  = 1'b0;
        lc_ready_out  = 1'b0;
        unique case (state_q)
            StIdle:   req_ready_out = grant;
            StLcReq:  lc_valid_out = 1'b1;
            StLcWait: lc_ready_out = 1'b1;
            StRsp:    rsp_valid_out[owner_q] = 1'b1;
            default:  ;
        endcase
    end

    // One payload register serves both directions: the request fields are
    // dead once the LLC has accepted them, so the response overwrites them.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            addr_q  <= '0;
            value_q <= '0;
            we_q    <= 1'b0;
            owner_q <= '0;
        end else if (grant_fire) begin
            addr_q  <= req_addr_in[win_idx];
            value_q <= req_value_in[win_idx];
            we_q    <= req_we_in[win_idx];
            owner_q <= win_idx;
        end else if (lc_rsp_fire) begin
            addr_q  <= lc_addr_in;
            value_q <= lc_value_in;
        end
    end

    assign lc_addr_out   = addr_q;
    assign lc_value_out  = value_q;
    assign lc_we_out     = we_q;
    assign rsp_addr_out  = addr_q;
    assign rsp_value_out = value_q;
    assign owner_out     = owner_q;
    assign busy_out      = (state_q != StIdle);

endmodule

// File: doc/llc_arbiter.md
LLC_ARBITER -- requirements
Module: llc_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 64, the request/response address width.
REQ-002 SHALL have parameter LINE_WIDTH, default 512, the cache-line data width in bits.
REQ-003 SHALL have parameter N_REQ, default 2, the requester count; index 0 = L1I, 1 = L1D.
REQ-004 clk_in  input  1  single clock; all state changes on the rising edge.
REQ-005 rst_in  input  1  reset, synchronous and active-high.
REQ-006 req_valid_in  input  N_REQ  per-requester request valid.
REQ-007 req_ready_out  output  N_REQ  per-requester grant; a handshake completes when valid and ready are both high.
REQ-008 req_addr_in  input  N_REQ x ADDR_WIDTH  request addresses.
REQ-009 req_value_in  input  N_REQ x LINE_WIDTH  write data.
REQ-010 req_we_in  input  N_REQ  write enable; 0 = read.
REQ-011 rsp_valid_out  output  N_REQ  response valid, one-hot to the owner.
REQ-012 rsp_ready_in  input  N_REQ  requester accepts the response.
REQ-013 rsp_addr_out  output  ADDR_WIDTH  shared response address.
REQ-014 rsp_value_out  output  LINE_WIDTH  shared response line.
REQ-015 lc_valid_out, lc_addr_out, lc_value_out, lc_we_out  output  1/ADDR_WIDTH/LINE_WIDTH/1  request to LLC.
REQ-016 lc_ready_in  input  1  LLC accepts request.
REQ-017 lc_valid_in, lc_addr_in, lc_value_in  input  1/ADDR_WIDTH/LINE_WIDTH  LLC response.
REQ-018 lc_ready_out  output  1  arbiter accepts LLC response.
REQ-019 owner_out  output  $clog2(N_REQ)  index of the current transaction owner; busy_out  output  1  high outside IDLE.

Function
REQ-020 SHALL implement FSM IDLE -> LC_REQ -> LC_WAIT -> RSP -> IDLE, with exactly one outstanding LLC transaction.
REQ-021 IDLE: if any req_valid_in is high, SHALL pick a winner, raise req_ready_out[winner] only (combinationally, that cycle), latch addr/value/we/owner, and go to LC_REQ next cycle.
REQ-022 LC_REQ: SHALL drive lc_valid_out=1 with the latched fields held stable; on lc_ready_in=1, go to LC_WAIT.
REQ-023 LC_WAIT: SHALL drive lc_ready_out=1; on lc_valid_in=1, capture lc_addr_in/lc_value_in and go to RSP.
REQ-024 RSP: SHALL drive rsp_valid_out[owner]=1 and hold the captured data stable; on rsp_ready_in[owner]=1, go to IDLE and update priority.
REQ-025 Latency: request accepted in cycle 0 -> lc_valid_out in cycle 1; LLC response in cycle k -> rsp_valid_out in cycle k+1. Minimum round trip is 3 cycles.
REQ-026 Writes SHALL also await one LLC response beat (ack), which is forwarded to the owner.
REQ-027 lc_valid_in outside LC_WAIT SHALL be ignored (lc_ready_out=0).
REQ-028 req_ready_out SHALL be all zero outside IDLE; requests arriving while busy wait, and none is dropped.
REQ-029 lc_ready_in asserted in the same cycle as lc_valid_in (a 1-cycle LLC) SHALL still take two FSM cycles; the response is not captured in LC_REQ.
REQ-030 A response for requester 0 SHALL never assert rsp_valid_out[1], and vice versa.

Reset
REQ-031 rst_in SHALL force IDLE, and all valid/ready outputs, lc_we_out, owner_out and busy_out to 0, clear the data registers to 0, and set the priority pointer to last_served=0.
REQ-032 Reset mid-transaction SHALL abandon it: no response is delivered, and an LLC response arriving later is ignored.

Configuration
REQ-033 With LLC_ARB_ROUND_ROBIN_EN defined: on contention, the requester not served last wins. After reset, L1D wins the first tie.
REQ-034 Without LLC_ARB_ROUND_ROBIN_EN: fixed priority, with the highest index (L1D) always winning; the pointer logic is absent.

Structure
REQ-035 Package llc_pkg SHALL hold the FSM state enum, the REQ_L1I/REQ_L1D index constants and the default widths.
REQ-036 One combinational sub-module, llc_arb_pick (request vector + last_served -> one-hot grant), SHALL contain all priority logic, including the macro switch.

Verification
REQ-037 Single read: L1I req addr 0x40 alone; LLC acks after 5 cycles with line 0xAB.. -> lc_addr_out=0x40 in cycle 1, rsp_valid_out=01 with value 0xAB.. in cycle after the ack.
REQ-038 Tie with RR: both valid continuously, 4 transactions -> grant order D,I,D,I. Without the macro -> D,D,D,D.
REQ-039 Write: L1D we=1 addr 0x80 data 0x55.. -> lc_we_out=1, lc_value_out=0x55..; the ack is returned on rsp_valid_out=10.
REQ-040 Backpressure: lc_ready_in low for 3 cycles, then rsp_ready_in low for 2 -> lc_valid_out and the fields stay stable for 3 cycles, rsp_valid_out holds for 2 cycles, and no second request is granted.
REQ-041 Stray and reset: lc_valid_in pulsed in IDLE -> no rsp_valid_out. rst_in in LC_WAIT then late lc_valid_in -> outputs 0 and no response.
